// File: rtl/exc_seq_pkg.sv
// exc_seq_pkg: state encoding, cause codes and flush masks shared by the exception sequencer.
package exc_seq_pkg;
  typedef enum logic [1:0] {IDLE, REDIRECT, HOLDOFF} state_t;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;
  // flush masks are {exe, id, if}
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_IF   = 3'b001;
  localparam logic [2:0] FL_IFID = 3'b011;
  localparam logic [2:0] FL_ALL  = 3'b111;
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: age-ordered priority encoder picking the winning exception/interrupt/ERET source.
module exc_prio_enc
  import exc_seq_pkg::*;
(
  input  logic       id_valid,
  input  logic       id_syscall,
  input  logic       id_unknown,
  input  logic       id_eret,
  input  logic       exe_overflow,
  input  logic       int_req,
  input  logic       status_exl,
  input  logic       int_en,
  output logic       hit,
  output logic [4:0] code,
  output logic [2:0] flush,
  output logic       is_eret,
  output logic       use_exe
);
  logic ri, sys, er, irq;
  always_comb begin
    ri  = id_valid & id_unknown;
    sys = id_valid & id_syscall;
    er  = id_valid & id_eret;
    irq = id_valid & int_req & ~status_exl & int_en;
    hit = exe_overflow | ri | sys | er | irq;
    use_exe = exe_overflow;
    is_eret = ~exe_overflow & ~ri & ~sys & er;
    code  = exe_overflow ? EXC_OV : ri ? EXC_RI : sys ? EXC_SYS : EXC_INT;
    flush = exe_overflow ? FL_ALL : (ri | sys) ? FL_IFID : er ? FL_IF : irq ? FL_IFID : FL_NONE;
  end
endmodule

// File: rtl/exc_sequencer.sv
// exc_sequencer: exception/interrupt/ERET entry-exit sequencer driving flushes, CP0 commits and fetch redirect.
// Optional post-ERET interrupt blackout enabled by defining EXC_SEQ_HOLDOFF_EN.
module exc_sequencer
  import exc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_BASE       = 32'h0000_0000,
  parameter logic [31:0] EXC_OFFSET     = 32'h0000_0180,
  parameter logic [31:0] INT_OFFSET     = 32'h0000_0200,
  parameter int          HOLDOFF_CYCLES = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_bd,
  input  logic        id_syscall,
  input  logic        id_unknown,
  input  logic        id_eret,
  input  logic        exe_overflow,
  input  logic [31:0] exe_pc,
  input  logic        exe_bd,
  input  logic        int_req,
  input  logic        status_exl,
  input  logic        cause_iv,
  input  logic [31:0] epc,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_exe,
  output logic        exc_commit,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic        eret_commit,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);
`ifdef EXC_SEQ_HOLDOFF_EN
  localparam bit HOLDOFF_EN = 1'b1;
`else
  localparam bit HOLDOFF_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [31:0] target, target_n, src_pc, vec;
  logic [7:0] cnt;
  logic was_eret, hit, is_eret, use_exe, accept, src_bd;
  logic [4:0] code;
  logic [2:0] flush;
  exc_prio_enc u_enc (
    .id_valid(id_valid), .id_syscall(id_syscall), .id_unknown(id_unknown), .id_eret(id_eret),
    .exe_overflow(exe_overflow), .int_req(int_req), .status_exl(status_exl),
    .int_en(state != HOLDOFF), .hit(hit), .code(code), .flush(flush),
    .is_eret(is_eret), .use_exe(use_exe)
  );
  // rst gates acceptance so outputs fall to zero as soon as reset asserts
  always_comb begin
    accept = rst & ~stall & hit & (state == IDLE || state == HOLDOFF);
    src_pc = use_exe ? exe_pc : id_pc;
    src_bd = use_exe ? exe_bd : id_bd;
    vec = EXC_BASE + ((code == EXC_INT && cause_iv) ? INT_OFFSET : EXC_OFFSET);
    target_n = accept ? (is_eret ? epc : vec) : target;
    state_n = accept ? REDIRECT : stall ? state :
              state == REDIRECT ? ((was_eret && HOLDOFF_EN) ? HOLDOFF : IDLE) :
              (state == HOLDOFF && cnt <= 8'd1) ? IDLE : state;
    flush_if    = accept & flush[0];
    flush_id    = accept & flush[1];
    flush_exe   = accept & flush[2];
    exc_commit  = accept & ~is_eret;
    eret_commit = accept & is_eret;
    exc_code    = exc_commit ? code : 5'd0;
    exc_epc     = exc_commit ? (src_bd ? src_pc - 32'd4 : src_pc) : 32'd0;
    exc_bd      = exc_commit & src_bd;
    redirect    = state == REDIRECT;
    redirect_pc = redirect ? target : 32'd0;
    busy        = state == REDIRECT;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      target   <= 32'd0;
      cnt      <= 8'd0;
      was_eret <= 1'b0;
    end else begin
      state    <= state_n;
      target   <= target_n;
      was_eret <= accept ? is_eret : was_eret;
      cnt      <= stall ? cnt : state == REDIRECT ? 8'(HOLDOFF_CYCLES) : state == HOLDOFF ? cnt - 8'd1 : cnt;
    end
  end
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: directed self-checking bench for exc_sequencer.
module tb_exc_sequencer;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0;
  logic id_valid = 1'b0, id_bd = 1'b0, id_syscall = 1'b0, id_unknown = 1'b0, id_eret = 1'b0;
  logic exe_overflow = 1'b0, exe_bd = 1'b0, int_req = 1'b0, status_exl = 1'b0, cause_iv = 1'b0;
  logic [31:0] id_pc = '0, exe_pc = '0, epc = '0;
  logic flush_if, flush_id, flush_exe, exc_commit, exc_bd, eret_commit, redirect, busy;
  logic [4:0] exc_code;
  logic [31:0] exc_epc, redirect_pc;
  int checks = 0, failures = 0;

  exc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .id_valid(id_valid), .id_pc(id_pc), .id_bd(id_bd),
    .id_syscall(id_syscall), .id_unknown(id_unknown), .id_eret(id_eret),
    .exe_overflow(exe_overflow), .exe_pc(exe_pc), .exe_bd(exe_bd), .int_req(int_req),
    .status_exl(status_exl), .cause_iv(cause_iv), .epc(epc), .flush_if(flush_if),
    .flush_id(flush_id), .flush_exe(flush_exe), .exc_commit(exc_commit), .exc_code(exc_code),
    .exc_epc(exc_epc), .exc_bd(exc_bd), .eret_commit(eret_commit), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_valid = 0; id_syscall = 0; id_unknown = 0; id_eret = 0; id_bd = 0;
    exe_overflow = 0; exe_bd = 0; int_req = 0; status_exl = 0; cause_iv = 0;
  endtask

  initial begin
    #12;
    chk("rst_redirect", {31'd0, redirect}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_commit", {31'd0, exc_commit}, 0);
    chk("rst_rpc", redirect_pc, 0);
    tick(); rst = 1;
    // 1: syscall
    id_valid = 1; id_syscall = 1; id_pc = 32'h100; #1;
    chk("t1_commit", {31'd0, exc_commit}, 1);
    chk("t1_code", {27'd0, exc_code}, 8);
    chk("t1_epc", exc_epc, 32'h100);
    chk("t1_bd", {31'd0, exc_bd}, 0);
    chk("t1_flush", {29'd0, flush_exe, flush_id, flush_if}, 3'b011);
    chk("t1_noredir", {31'd0, redirect}, 0);
    tick(); #1;
    chk("t1_ignored_busy", {31'd0, exc_commit}, 0);
    chk("t1_redirect", {31'd0, redirect}, 1);
    chk("t1_rpc", redirect_pc, 32'h180);
    chk("t1_busy", {31'd0, busy}, 1);
    clear(); tick();
    chk("t1_idle", {30'd0, busy, redirect}, 0);
    // 2: overflow beats syscall
    exe_overflow = 1; exe_pc = 32'h204; exe_bd = 1; id_valid = 1; id_syscall = 1; id_pc = 32'h300; #1;
    chk("t2_code", {27'd0, exc_code}, 12);
    chk("t2_epc", exc_epc, 32'h200);
    chk("t2_bd", {31'd0, exc_bd}, 1);
    chk("t2_flush", {29'd0, flush_exe, flush_id, flush_if}, 3'b111);
    tick(); clear(); #1;
    chk("t2_rpc", redirect_pc, 32'h180);
    tick();
    // RI beats syscall, delay-slot EPC from ID
    id_valid = 1; id_unknown = 1; id_syscall = 1; id_bd = 1; id_pc = 32'h500; #1;
    chk("ri_code", {27'd0, exc_code}, 10);
    chk("ri_epc", exc_epc, 32'h4fc);
    tick(); clear(); tick();
    // 3: interrupt with IV
    int_req = 1; cause_iv = 1; id_valid = 1; id_pc = 32'h40; #1;
    chk("t3_commit", {31'd0, exc_commit}, 1);
    chk("t3_code", {27'd0, exc_code}, 0);
    chk("t3_epc", exc_epc, 32'h40);
    tick(); clear(); #1;
    chk("t3_rpc", redirect_pc, 32'h200);
    tick();
    int_req = 1; cause_iv = 1; id_valid = 1; status_exl = 1; #1;
    chk("t3_exl_commit", {31'd0, exc_commit}, 0);
    chk("t3_exl_flush", {31'd0, flush_if}, 0);
    tick();
    chk("t3_exl_redir", {31'd0, redirect}, 0);
    status_exl = 0; id_valid = 0; #1;
    chk("t3_bubble_commit", {31'd0, exc_commit}, 0);
    clear(); tick();
    // 4: ERET
    id_valid = 1; id_eret = 1; epc = 32'h1234; #1;
    chk("t4_eret", {31'd0, eret_commit}, 1);
    chk("t4_exc", {31'd0, exc_commit}, 0);
    chk("t4_flush", {29'd0, flush_exe, flush_id, flush_if}, 3'b001);
    tick(); clear(); #1;
    chk("t4_rpc", redirect_pc, 32'h1234);
    tick();
    int_req = 1; id_valid = 1; #1;
`ifdef EXC_SEQ_HOLDOFF_EN
    chk("t4_hold0", {31'd0, exc_commit}, 0);
    chk("t4_hold_busy", {31'd0, busy}, 0);
    tick();
    chk("t4_hold1", {31'd0, exc_commit}, 0);
    tick();
`endif
    chk("t4_int_after", {31'd0, exc_commit}, 1);
    tick(); clear(); tick();
    // stall in IDLE blocks acceptance
    stall = 1; id_valid = 1; id_syscall = 1; id_pc = 32'h100; #1;
    chk("stall_idle", {31'd0, exc_commit}, 0);
    stall = 0; #1;
    chk("unstall_accept", {31'd0, exc_commit}, 1);
    // 5: stalled REDIRECT holds
    tick(); clear(); stall = 1; #1;
    chk("t5_r1", {31'd0, redirect}, 1);
    tick();
    chk("t5_r2", {31'd0, redirect}, 1);
    tick();
    chk("t5_r3", {31'd0, redirect}, 1);
    stall = 0; #1;
    chk("t5_r4", {31'd0, redirect}, 1);
    tick();
    chk("t5_done", {31'd0, redirect}, 0);
    // async reset mid-REDIRECT
    id_valid = 1; id_syscall = 1; tick(); clear(); #1;
    chk("rst_mid_pre", {31'd0, redirect}, 1);
    rst = 0; #1;
    chk("rst_mid_redir", {31'd0, redirect}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_rpc", redirect_pc, 0);
    tick(); rst = 1; tick();
    chk("rst_after", {30'd0, busy, redirect}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
